// File: rtl/fdiv_seq_if.sv
// fdiv_seq_if: start/ready/done request bundle between an issuer and fdiv_seq.
interface fdiv_seq_if #(parameter int EXP = 8, parameter int FRAC = 23);
  localparam int WIDTH = EXP + FRAC + 1;
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0] round_mode;
  logic ready;
  logic done;
  logic [WIDTH-1:0] r;
  logic [4:0] flags;
  modport master (output start, a, b, round_mode, input ready, done, r, flags);
  modport slave (input start, a, b, round_mode, output ready, done, r, flags);
endinterface

// File: rtl/fdiv_seq.sv
// fdiv_seq: multi-cycle restoring radix-2 floating-point divider with four rounding modes.
module fdiv_seq #(parameter int EXP = 8, parameter int FRAC = 23) (
  input logic clk,
  input logic rst_n,
  fdiv_seq_if.slave bus
);
  localparam int WIDTH = EXP + FRAC + 1;
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam int CW = $clog2(FRAC + 4);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [WIDTH-2:0] INF = {{EXP{1'b1}}, {FRAC{1'b0}}};
  localparam logic [WIDTH-2:0] MAXF = {{(EXP-1){1'b1}}, 1'b0, {FRAC{1'b1}}};
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  function automatic int lzc(input logic [FRAC:0] m);
    lzc = FRAC + 1;
    for (int i = 0; i <= FRAC; i++) if (m[i]) lzc = FRAC - i;
  endfunction
  state_t state;
  logic sign, special;
  logic [1:0] mode;
  logic signed [EXP+1:0] exp_r;
  logic [FRAC:0] mb;
  logic [FRAC+1:0] rem;
  logic [FRAC+3:0] q;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sp_r;
  logic [4:0] sp_flags;
  logic sa, sb;
  logic [EXP-1:0] ea, eb;
  logic [FRAC-1:0] fa, fb;
  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sp;
  logic [FRAC:0] ma_n, mb_n;
  int la, lb, ea_eff, eb_eff;
  logic [WIDTH-1:0] sp_r_n;
  logic [4:0] sp_f_n;
  always_comb begin
    a_nan = &ea && |fa;
    b_nan = &eb && |fb;
    a_inf = &ea && !(|fa);
    b_inf = &eb && !(|fb);
    a_zero = !(|ea) && !(|fa);
    b_zero = !(|eb) && !(|fb);
    // subnormals are shifted up until the hidden bit is set, trading exponent for it
    la = lzc({|ea, fa});
    lb = lzc({|eb, fb});
    ma_n = {|ea, fa} << la;
    mb_n = {|eb, fb} << lb;
    ea_eff = |ea ? int'(ea) : 1 - la;
    eb_eff = |eb ? int'(eb) : 1 - lb;
    sp = 1'b1;
    sp_r_n = '0;
    sp_f_n = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_r_n = QNAN;
      sp_f_n = 5'b10000;
    end else if (a_inf) sp_r_n = {sa ^ sb, INF};
    else if (b_zero) begin
      sp_r_n = {sa ^ sb, INF};
      sp_f_n = 5'b01000;
    end else if (b_inf || a_zero) sp_r_n = {sa ^ sb, {(WIDTH-1){1'b0}}};
    else sp = 1'b0;
  end
  logic qb, hi, g, rb, s, inc, carry, ovf, unf, to_inf;
  logic [FRAC:0] mant;
  logic [FRAC+1:0] mant_i;
  logic signed [EXP+1:0] e_n;
  logic [WIDTH-1:0] res;
  logic [4:0] fl;
  always_comb begin
    qb = rem >= {1'b0, mb};
    hi = q[FRAC+3];
    mant = hi ? q[FRAC+3:3] : q[FRAC+2:2];
    g = hi ? q[2] : q[1];
    rb = hi ? q[1] : q[0];
    s = (hi & q[0]) | (|rem);
    inc = mode == 2'b00 ? g & (rb | s | mant[0]) :
          mode == 2'b01 ? 1'b0 :
          mode == 2'b10 ? !sign & (g | rb | s) : sign & (g | rb | s);
    mant_i = {1'b0, mant} + (FRAC+2)'(inc);
    carry = mant_i[FRAC+1];
    e_n = exp_r - (EXP+2)'(!hi) + (EXP+2)'(carry);
    ovf = int'(e_n) >= (1 << EXP) - 1;
    unf = int'(e_n) <= 0;
    to_inf = mode == 2'b00 || (mode == 2'b10 && !sign) || (mode == 2'b11 && sign);
    res = special ? sp_r :
          ovf ? {sign, to_inf ? INF : MAXF} :
          unf ? {sign, {(WIDTH-1){1'b0}}} : {sign, e_n[EXP-1:0], mant_i[FRAC-1:0]};
    fl = special ? sp_flags : {2'b00, ovf, unf, ovf | unf | g | rb | s};
  end
  // specials pass through ROUND so their result lands one edge after accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
      bus.r <= '0;
      bus.flags <= '0;
      sign <= 1'b0;
      special <= 1'b0;
      mode <= '0;
      exp_r <= '0;
      mb <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      sp_r <= '0;
      sp_flags <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bus.ready <= 1'b0;
          sign <= sa ^ sb;
          mode <= bus.round_mode;
          special <= sp;
          sp_r <= sp_r_n;
          sp_flags <= sp_f_n;
          mb <= mb_n;
          rem <= {1'b0, ma_n};
          q <= '0;
          cnt <= CW'(FRAC + 3);
          exp_r <= (EXP+2)'(ea_eff - eb_eff + BIAS);
          state <= sp ? ROUND : DIV;
        end
        DIV: begin
          q <= {q[FRAC+2:0], qb};
          rem <= (qb ? rem - {1'b0, mb} : rem) << 1;
          if (cnt == '0) state <= ROUND;
          else cnt <= cnt - 1'b1;
        end
        ROUND: begin
          bus.r <= res;
          bus.flags <= fl;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed and randomized checks of fdiv_seq against an arithmetic reference model.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_r;
  logic [4:0] last_flags;
  fdiv_seq_if bus ();
  fdiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // exact quotient via integer division; rounding decided from the discarded quarter-ulps
  task automatic model(input logic [31:0] a, b, input logic [1:0] m,
                       output logic [31:0] er, output logic [4:0] ef, output int el);
    logic s;
    int ea, eb, e;
    longint ma, mb, sig, mant, quarters;
    bit an, bn, ai, bi, az, bz, st, inx, up, odd, to_inf;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    an = ea == 255 && ma != 0;
    bn = eb == 255 && mb != 0;
    ai = ea == 255 && ma == 0;
    bi = eb == 255 && mb == 0;
    az = ea == 0 && ma == 0;
    bz = eb == 0 && mb == 0;
    el = 1;
    ef = 5'b0;
    er = 32'h0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      er = 32'h7FC00000;
      ef = 5'b10000;
    end else if (ai) er = {s, 31'h7F800000};
    else if (bz) begin
      er = {s, 31'h7F800000};
      ef = 5'b01000;
    end else if (bi || az) er = {s, 31'h0};
    else begin
      el = 28;
      if (ea == 0) ea = 1; else ma += 64'd1 << 23;
      if (eb == 0) eb = 1; else mb += 64'd1 << 23;
      while (ma < (64'd1 << 23)) begin ma = ma * 2; ea--; end
      while (mb < (64'd1 << 23)) begin mb = mb * 2; eb--; end
      e = ea - eb + 127;
      if (ma < mb) begin ma = ma * 2; e--; end
      sig = (ma << 25) / mb;
      st = ((ma << 25) % mb) != 0;
      mant = sig / 4;
      quarters = sig % 4;
      inx = quarters != 0 || st;
      odd = (mant % 2) == 1;
      case (m)
        2'b00: up = quarters > 2 || (quarters == 2 && (st || odd));
        2'b01: up = 1'b0;
        2'b10: up = inx && !s;
        default: up = inx && s;
      endcase
      mant += longint'(up);
      if (mant == (64'd1 << 24)) begin mant = mant / 2; e++; end
      to_inf = m == 2'b00 || (m == 2'b10 && !s) || (m == 2'b11 && s);
      if (e >= 255) begin
        er = to_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
        ef = 5'b00101;
      end else if (e <= 0) begin
        er = {s, 31'h0};
        ef = 5'b00011;
      end else begin
        er = {s, 8'(e), 23'(mant)};
        ef = {4'b0, inx};
      end
    end
  endtask
  task automatic wait_done(input int lat0, output int lat, output bit rdy_ok);
    lat = lat0;
    rdy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, b, input logic [1:0] m);
    logic [31:0] er;
    logic [4:0] ef;
    int el, lat;
    bit rdy_ok;
    model(a, b, m, er, ef, el);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.round_mode = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.round_mode = 2'($urandom);
    wait_done(0, lat, rdy_ok);
    check({tag, "_lat"}, lat, el);
    check({tag, "_r"}, bus.r, er);
    check({tag, "_flags"}, bus.flags, ef);
    check({tag, "_busy"}, {rdy_ok, bus.ready}, 2'b10);
    last_r = bus.r;
    last_flags = bus.flags;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {bus.done, bus.ready}, 2'b01);
  endtask
  function automatic logic [31:0] rnd_op();
    int k;
    logic [22:0] f;
    logic s;
    logic [7:0] e;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    s = 1'($urandom);
    e = 8'($urandom_range(1, 254));
    case (k)
      0: return {s, 31'h0};
      1: return {s, 8'h00, f};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'hFF, f | 23'h1};
      4: return {s, 8'($urandom_range(240, 254)), f};
      5: return {s, 8'($urandom_range(1, 12)), f};
      default: return {s, e, f};
    endcase
  endfunction
  initial begin
    int lat;
    bit rdy_ok, quiet;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.round_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.ready, bus.done, bus.r, bus.flags}, {1'b1, 1'b0, 32'h0, 5'h0});
    rst_n = 1'b1;
    run_op("div6_2", 32'h40C00000, 32'h40000000, 2'b00);
    check("div6_2_spec", {last_r, last_flags}, {32'h40400000, 5'b00000});
    run_op("third_rne", 32'h3F800000, 32'h40400000, 2'b00);
    check("third_rne_spec", {last_r, last_flags}, {32'h3EAAAAAB, 5'b00001});
    run_op("third_rtz", 32'h3F800000, 32'h40400000, 2'b01);
    check("third_rtz_spec", {last_r, last_flags}, {32'h3EAAAAAA, 5'b00001});
    run_op("third_rup", 32'h3F800000, 32'h40400000, 2'b10);
    check("third_rup_spec", last_r, 32'h3EAAAAAB);
    run_op("third_rdn", 32'hBF800000, 32'h40400000, 2'b11);
    check("third_rdn_spec", last_r, 32'hBEAAAAAB);
    run_op("divzero", 32'h3F800000, 32'h00000000, 2'b00);
    check("divzero_spec", {last_r, last_flags}, {32'h7F800000, 5'b01000});
    run_op("zero_zero", 32'h00000000, 32'h00000000, 2'b00);
    check("zero_zero_spec", {last_r, last_flags}, {32'h7FC00000, 5'b10000});
    run_op("nan_in", 32'h7FC00001, 32'h3F800000, 2'b00);
    check("nan_in_spec", {last_r, last_flags}, {32'h7FC00000, 5'b10000});
    run_op("ovf_rne", 32'h7F000000, 32'h3E800000, 2'b00);
    check("ovf_rne_spec", {last_r, last_flags}, {32'h7F800000, 5'b00101});
    run_op("ovf_rtz", 32'h7F000000, 32'h3E800000, 2'b01);
    check("ovf_rtz_spec", {last_r, last_flags}, {32'h7F7FFFFF, 5'b00101});
    run_op("ovf_rdn", 32'h7F000000, 32'h3E800000, 2'b11);
    run_op("ovf_rup_neg", 32'hFF000000, 32'h3E800000, 2'b10);
    run_op("sub_sub", 32'h00000001, 32'h00000001, 2'b00);
    check("sub_sub_spec", {last_r, last_flags}, {32'h3F800000, 5'b00000});
    run_op("unf", 32'h00800000, 32'h40000000, 2'b00);
    check("unf_spec", {last_r, last_flags}, {32'h00000000, 5'b00011});
    run_op("inf_fin", 32'hFF800000, 32'h40000000, 2'b00);
    run_op("fin_inf", 32'h40000000, 32'hFF800000, 2'b00);
    // a second start five cycles into a divide must be dropped
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    bus.round_mode = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(5, lat, rdy_ok);
    check("ignore_lat", lat, 28);
    check("ignore_r", bus.r, 32'h40400000);
    @(posedge clk); #1;
    check("ignore_idle", {bus.done, bus.ready}, 2'b01);
    // reset mid-divide, with a start presented in the same cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    @(posedge clk); #1;
    check("mid_reset", {bus.ready, bus.done, bus.r, bus.flags}, {1'b1, 1'b0, 32'h0, 5'h0});
    rst_n = 1'b1;
    bus.start = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) quiet = 1'b0;
    end
    check("no_done_after_reset", {quiet, bus.r}, {1'b1, 32'h0});
    for (int i = 0; i < 300; i++) run_op("rand", rnd_op(), rnd_op(), 2'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
